// File: rtl/uart_boot_loader_ctrl.sv
// Packs UART bytes LSB-first into 32-bit words and writes them to instruction memory, holding the CPU in reset until the last word is written.
// Write pulse lands one cycle after the 4th byte; no backpressure, so a byte is taken every cycle rx_valid is high.
module uart_boot_loader_ctrl #(
  parameter int NUM_WORDS      = 64,
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_rst,
  output logic                  load_done,
  output logic                  timeout_err
);

  localparam int WCW = $clog2(NUM_WORDS + 1);
  localparam int IDW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic {S_LOAD, S_RUN} state_t;

  state_t                r_state, w_state_nxt;
  logic [23:0]           r_shift;
  logic [1:0]            r_byte_cnt;
  logic [WCW-1:0]        r_word_cnt;
  logic [ADDR_WIDTH-1:0] r_addr_cnt;
  logic [IDW-1:0]        r_idle_cnt;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [31:0]           r_mem_wdata;
  logic                  r_timeout_err;
  logic                  w_accept;
  logic                  w_word_done;
  logic                  w_timeout;
  logic                  w_last_word;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_LOAD;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_word_done = 1'b0;
    w_timeout   = 1'b0;
    w_last_word = (r_word_cnt == WCW'(NUM_WORDS - 1));
    if (r_state == S_LOAD) begin
      w_accept    = rx_valid;
      w_word_done = rx_valid && (r_byte_cnt == 2'd3);
      // An arriving byte always wins over an expiring idle counter.
      w_timeout   = !rx_valid && (r_byte_cnt != 2'd0) &&
                    (r_idle_cnt == IDW'(TIMEOUT_CYCLES - 1));
      if (w_word_done && w_last_word) w_state_nxt = S_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift       <= '0;
      r_byte_cnt    <= '0;
      r_word_cnt    <= '0;
      r_addr_cnt    <= '0;
      r_idle_cnt    <= '0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_mem_we <= w_word_done;
      if (w_accept) begin
        r_byte_cnt <= r_byte_cnt + 2'd1;
        r_idle_cnt <= '0;
        case (r_byte_cnt)
          2'd0:    r_shift[7:0]   <= rx_data;
          2'd1:    r_shift[15:8]  <= rx_data;
          2'd2:    r_shift[23:16] <= rx_data;
          default: ;
        endcase
      end else if (w_timeout) begin
        r_byte_cnt    <= '0;
        r_idle_cnt    <= '0;
        r_timeout_err <= 1'b1;
      end else if (r_state == S_LOAD && r_byte_cnt != 2'd0) begin
        r_idle_cnt <= r_idle_cnt + IDW'(1);
      end else begin
        r_idle_cnt <= '0;
      end
      // The 4th byte bypasses the shift register so the word is complete this edge.
      if (w_word_done) begin
        r_mem_addr  <= r_addr_cnt;
        r_mem_wdata <= {rx_data, r_shift};
        r_word_cnt  <= r_word_cnt + WCW'(1);
        r_addr_cnt  <= r_addr_cnt + ADDR_WIDTH'(1);
      end
    end
  end

  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign cpu_rst     = (r_state != S_RUN);
  assign load_done   = (r_state == S_RUN);
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_boot_loader_ctrl.sv
// Scoreboarded bench: dut_a (2 words) covers reset, assembly, release, back-to-back and timeout;
// dut_b (4 words) covers reset in the middle of a load.
module tb_uart_boot_loader_ctrl;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    bit          last;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, rxv_a, rxv_b;
  logic [7:0]  rxd;
  logic        we_a, cpur_a, done_a, terr_a;
  logic        we_b, cpur_b, done_b, terr_b;
  logic [7:0]  addr_a, addr_b;
  logic [31:0] wd_a, wd_b;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  uart_boot_loader_ctrl #(.NUM_WORDS(2), .ADDR_WIDTH(8), .TIMEOUT_CYCLES(10)) dut_a (
    .clk(clk), .rst(rst_a), .rx_valid(rxv_a), .rx_data(rxd),
    .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wd_a),
    .cpu_rst(cpur_a), .load_done(done_a), .timeout_err(terr_a)
  );

  uart_boot_loader_ctrl #(.NUM_WORDS(4), .ADDR_WIDTH(8), .TIMEOUT_CYCLES(10)) dut_b (
    .clk(clk), .rst(rst_b), .rx_valid(rxv_b), .rx_data(rxd),
    .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wd_b),
    .cpu_rst(cpur_b), .load_done(done_b), .timeout_err(terr_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [7:0] a, input logic [31:0] d);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got write addr 0x%02h data 0x%08h, expected no write", name, a, d);
  endtask

  // Monitor: every write pulse is matched against the next queued expectation.
  always @(negedge clk) begin
    if (we_a === 1'b1) begin
      if (qa.size() == 0) unexpected("a_write", addr_a, wd_a);
      else begin
        ea = qa.pop_front();
        check("a_addr", addr_a, ea.addr);
        check("a_wdata", wd_a, ea.data);
        check("a_cpu_rst_at_write", cpur_a, !ea.last);
        check("a_load_done_at_write", done_a, ea.last);
      end
    end
    if (we_b === 1'b1) begin
      if (qb.size() == 0) unexpected("b_write", addr_b, wd_b);
      else begin
        eb = qb.pop_front();
        check("b_addr", addr_b, eb.addr);
        check("b_wdata", wd_b, eb.data);
        check("b_cpu_rst_at_write", cpur_b, !eb.last);
        check("b_load_done_at_write", done_b, eb.last);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic send(input bit sel, input logic [7:0] b);
    if (sel) rxv_b = 1'b1;
    else     rxv_a = 1'b1;
    rxd = b;
    tick();
    rxv_a = 1'b0;
    rxv_b = 1'b0;
  endtask

  task automatic send_word(input bit sel, input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) begin
      send(sel, w[8*i +: 8]);
      idle(gap);
    end
  endtask

  task automatic pulse_rst(input bit sel);
    if (sel) rst_b = 1'b1;
    else     rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    rst_b = 1'b0;
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    rxv_a = 1'b0; rxv_b = 1'b0;
    rxd   = 8'h00;
    idle(3);
    sample();
    check("rst_mem_we", we_a, 0);
    check("rst_mem_addr", addr_a, 0);
    check("rst_mem_wdata", wd_a, 0);
    check("rst_cpu_rst", cpur_a, 1);
    check("rst_load_done", done_a, 0);
    check("rst_timeout_err", terr_a, 0);
    rst_a = 1'b0; rst_b = 1'b0;
    tick();

    // Single word, consecutive bytes: one-cycle pulse right after the 4th byte.
    qa.push_back('{8'd0, 32'h00808093, 1'b0});
    send_word(0, 32'h00808093, 0);
    sample();
    check("single_we_high", we_a, 1);
    tick();
    sample();
    check("single_we_low", we_a, 0);
    check("single_cpu_rst_held", cpur_a, 1);

    // Full load with gaps, then release; later bytes must not write.
    pulse_rst(0);
    qa.push_back('{8'd0, 32'h00808093, 1'b0});
    qa.push_back('{8'd1, 32'h00001463, 1'b1});
    send_word(0, 32'h00808093, 3);
    send_word(0, 32'h00001463, 3);
    sample();
    check("full_cpu_rst_released", cpur_a, 0);
    check("full_load_done", done_a, 1);
    send_word(0, 32'hFFFFFFFF, 0);
    idle(3);
    sample();
    check("run_load_done_held", done_a, 1);
    check("run_addr_held", addr_a, 1);
    check("run_wdata_held", wd_a, 32'h00001463);

    // Back-to-back bytes across a word boundary.
    pulse_rst(0);
    qa.push_back('{8'd0, 32'h04030201, 1'b0});
    qa.push_back('{8'd1, 32'h08070605, 1'b1});
    send_word(0, 32'h04030201, 0);
    sample();
    check("b2b_we_first", we_a, 1);
    send_word(0, 32'h08070605, 0);
    idle(2);
    sample();
    check("b2b_load_done", done_a, 1);

    // Timeout: fires on the 10th idle edge, not the 9th.
    pulse_rst(0);
    send(0, 8'hAA);
    send(0, 8'hBB);
    idle(9);
    sample();
    check("timeout_not_yet", terr_a, 0);
    idle(1);
    sample();
    check("timeout_fired", terr_a, 1);
    idle(2);
    qa.push_back('{8'd0, 32'h44332211, 1'b0});
    send_word(0, 32'h44332211, 0);
    idle(2);
    sample();
    check("timeout_sticky", terr_a, 1);
    check("timeout_not_done", done_a, 0);

    // Reset in the middle of a load restarts at address 0.
    qb.push_back('{8'd0, 32'hA5A5A5A5, 1'b0});
    send_word(1, 32'hA5A5A5A5, 0);
    send(1, 8'h55);
    send(1, 8'h66);
    idle(2);
    pulse_rst(1);
    sample();
    check("midrst_addr", addr_b, 0);
    check("midrst_wdata", wd_b, 0);
    check("midrst_cpu_rst", cpur_b, 1);
    qb.push_back('{8'd0, 32'hDEADBEEF, 1'b0});
    qb.push_back('{8'd1, 32'h00000013, 1'b0});
    qb.push_back('{8'd2, 32'h12345678, 1'b0});
    qb.push_back('{8'd3, 32'hCAFEF00D, 1'b1});
    send_word(1, 32'hDEADBEEF, 1);
    send_word(1, 32'h00000013, 1);
    send_word(1, 32'h12345678, 1);
    sample();
    check("midrst_not_done_early", done_b, 0);
    send_word(1, 32'hCAFEF00D, 1);
    idle(2);
    sample();
    check("midrst_load_done", done_b, 1);
    check("midrst_timeout_err", terr_b, 0);

    idle(3);
    check("a_queue_drained", qa.size(), 0);
    check("b_queue_drained", qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
